wdg_kicker: RTL and testbench

- Servicing side of the board watchdog: drives the watchdog enable and kick strobe, and receives its active-low timeout pulse.
- Kicks periodically, paced by the shared 10 Hz tick, only while every monitored software heartbeat is alive.
- Stops kicking on a stale heartbeat or a forced stop, so the watchdog times out. Records which heartbeat failed and counts trips.

---
 rtl/wdg_kicker.sv | 165 ++++++++++++++++
 tb/tb_wdg_kicker.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wdg_kicker.sv
// rtl/wdg_kicker.sv - watchdog servicing FSM that kicks only while all heartbeats are alive
//
// Purpose: drives the board watchdog enable and kick strobe. Kicks are paced by
// the shared 10 Hz tick and stop as soon as a heartbeat goes stale or software
// forces a stop, so the watchdog is allowed to time out. Records which heartbeat
// failed and counts observed timeout pulses.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clk_10hz_fp         one-clk 10 Hz tick pulse
//   enable              level; a rising edge arms the kicker
//   force_stop          level; deliberately starves the watchdog while running
//   health_hb[N_HB]     per-task heartbeats; any toggle means alive
//   zynq_wdog_timeout   watchdog timeout pulse, active low
//   wdg_en, wdg_kick    watchdog enable and one-clk kick strobe
//   fault_mask[N_HB]    sticky per-heartbeat timeout flags
//   state               IDLE=0 ARM=1 RUN=2 STARVE=3 TRIPPED=4
//   trip_cnt            saturating count of observed timeout pulses
module wdg_kicker #(
   parameter int N_HB        = 2,
   parameter int KICK_PERIOD = 4,
   parameter int HB_TIMEOUT  = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clk_10hz_fp,
   input  logic            enable,
   input  logic            force_stop,
   input  logic [N_HB-1:0] health_hb,
   input  logic            zynq_wdog_timeout,
   output logic            wdg_en,
   output logic            wdg_kick,
   output logic [N_HB-1:0] fault_mask,
   output logic [2:0]      state,
   output logic [7:0]      trip_cnt
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARM     = 3'd1,
      S_RUN     = 3'd2,
      S_STARVE  = 3'd3,
      S_TRIPPED = 3'd4
   } state_e;

   localparam logic [7:0] KICK_RELOAD = 8'(KICK_PERIOD - 1);
   localparam logic [7:0] HB_LIMIT    = 8'(HB_TIMEOUT);

   state_e          state_q;
   logic            enable_d_q;
   logic [N_HB-1:0] hb_d_q;
   logic [7:0]      kick_timer_q;
   logic [7:0]      hb_timer_q [N_HB];
   logic            wdg_en_q;
   logic            wdg_kick_q;
   logic [N_HB-1:0] fault_mask_q;
   logic [7:0]      trip_cnt_q;

   logic [7:0]      hb_timer_d [N_HB];
   logic [N_HB-1:0] fault_mask_d;
   logic [7:0]      trip_cnt_d;

   // Heartbeat ageing as it would apply in RUN. A toggle beats a coincident tick,
   // and a timer reaching the limit flags its fault in the same cycle so the
   // FSM can suppress a kick that happens to be due at that moment.
   always_comb begin
      fault_mask_d = fault_mask_q;
      for (int i = 0; i < N_HB; i++) begin
         hb_timer_d[i] = hb_timer_q[i];
         if (health_hb[i] != hb_d_q[i]) begin
            hb_timer_d[i] = '0;
         end else if (clk_10hz_fp && (hb_timer_q[i] != HB_LIMIT)) begin
            hb_timer_d[i] = hb_timer_q[i] + 8'd1;
         end
         if (hb_timer_d[i] == HB_LIMIT) begin
            fault_mask_d[i] = 1'b1;
         end
      end
   end

   assign trip_cnt_d = (trip_cnt_q == 8'hFF) ? trip_cnt_q : trip_cnt_q + 8'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         enable_d_q   <= 1'b0;
         hb_d_q       <= '0;
         kick_timer_q <= '0;
         for (int i = 0; i < N_HB; i++) hb_timer_q[i] <= '0;
         wdg_en_q     <= 1'b0;
         wdg_kick_q   <= 1'b0;
         fault_mask_q <= '0;
         trip_cnt_q   <= '0;
      end else begin
         enable_d_q <= enable;
         hb_d_q     <= health_hb;
         wdg_kick_q <= 1'b0;

         if (!enable) begin
            state_q  <= S_IDLE;
            wdg_en_q <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  // Edge, not level: a level left high after a trip must not re-arm.
                  if (!enable_d_q) begin
                     state_q      <= S_ARM;
                     wdg_en_q     <= 1'b1;
                     wdg_kick_q   <= 1'b1;
                     fault_mask_q <= '0;
                     kick_timer_q <= KICK_RELOAD;
                     for (int i = 0; i < N_HB; i++) hb_timer_q[i] <= '0;
                  end
               end
               S_ARM: begin
                  state_q <= S_RUN;
               end
               S_RUN: begin
                  if (!zynq_wdog_timeout) begin
                     state_q    <= S_TRIPPED;
                     trip_cnt_q <= trip_cnt_d;
                  end else if (force_stop || (fault_mask_d != '0)) begin
                     state_q      <= S_STARVE;
                     fault_mask_q <= fault_mask_d;
                     hb_timer_q   <= hb_timer_d;
                  end else begin
                     hb_timer_q <= hb_timer_d;
                     if (clk_10hz_fp) begin
                        if (kick_timer_q == 8'd0) begin
                           wdg_kick_q   <= 1'b1;
                           kick_timer_q <= KICK_RELOAD;
                        end else begin
                           kick_timer_q <= kick_timer_q - 8'd1;
                        end
                     end
                  end
               end
               S_STARVE: begin
                  if (!zynq_wdog_timeout) begin
                     state_q    <= S_TRIPPED;
                     trip_cnt_q <= trip_cnt_d;
                  end
               end
               S_TRIPPED: begin
                  if (zynq_wdog_timeout) begin
                     state_q  <= S_IDLE;
                     wdg_en_q <= 1'b0;
                  end
               end
               default: begin
                  state_q  <= S_IDLE;
                  wdg_en_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign wdg_en     = wdg_en_q;
   assign wdg_kick   = wdg_kick_q;
   assign fault_mask = fault_mask_q;
   assign state      = state_q;
   assign trip_cnt   = trip_cnt_q;

endmodule

// File: tb/tb_wdg_kicker.sv
// tb/tb_wdg_kicker.sv - self-checking bench for wdg_kicker
module tb_wdg_kicker;

   localparam int N_HB        = 2;
   localparam int KICK_PERIOD = 4;
   localparam int HB_TIMEOUT  = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            clk_10hz_fp;
   logic            enable;
   logic            force_stop;
   logic [N_HB-1:0] health_hb;
   logic            zynq_wdog_timeout;
   logic            wdg_en;
   logic            wdg_kick;
   logic [N_HB-1:0] fault_mask;
   logic [2:0]      state;
   logic [7:0]      trip_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int kicks   = 0;
   bit chk_on  = 1'b0;

   wdg_kicker #(
      .N_HB(N_HB), .KICK_PERIOD(KICK_PERIOD), .HB_TIMEOUT(HB_TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .clk_10hz_fp(clk_10hz_fp), .enable(enable),
      .force_stop(force_stop), .health_hb(health_hb),
      .zynq_wdog_timeout(zynq_wdog_timeout), .wdg_en(wdg_en), .wdg_kick(wdg_kick),
      .fault_mask(fault_mask), .state(state), .trip_cnt(trip_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: tracks heartbeat ages in ticks since last toggle and
   // counts RUN ticks since arming; kicks fall on multiples of KICK_PERIOD.
   int              m_state;
   bit              m_en, m_kick;
   logic [N_HB-1:0] m_fault;
   int              m_trip;
   int              m_age [N_HB];
   int              m_run_ticks;
   bit              m_enable_prev;
   logic [N_HB-1:0] m_hb_prev;

   task automatic model_reset();
      m_state = 0; m_en = 0; m_kick = 0; m_fault = '0; m_trip = 0;
      m_run_ticks = 0; m_enable_prev = 0; m_hb_prev = '0;
      for (int i = 0; i < N_HB; i++) m_age[i] = 0;
   endtask

   task automatic model_step();
      logic [N_HB-1:0] tog, nf;
      tog = health_hb ^ m_hb_prev;
      m_kick = 0;
      if (!enable) begin
         m_state = 0; m_en = 0;
      end else begin
         case (m_state)
            0: if (!m_enable_prev) begin
                  m_state = 1; m_en = 1; m_kick = 1; m_fault = '0; m_run_ticks = 0;
                  for (int i = 0; i < N_HB; i++) m_age[i] = 0;
               end
            1: m_state = 2;
            2: if (!zynq_wdog_timeout) begin
                  m_state = 4; if (m_trip < 255) m_trip++;
               end else begin
                  nf = m_fault;
                  for (int i = 0; i < N_HB; i++) begin
                     if (tog[i]) m_age[i] = 0;
                     else if (clk_10hz_fp && m_age[i] < HB_TIMEOUT) m_age[i]++;
                     if (m_age[i] >= HB_TIMEOUT) nf[i] = 1'b1;
                  end
                  if (force_stop || nf != '0) begin
                     m_state = 3; m_fault = nf;
                  end else if (clk_10hz_fp) begin
                     m_run_ticks++;
                     if (m_run_ticks % KICK_PERIOD == 0) m_kick = 1;
                  end
               end
            3: if (!zynq_wdog_timeout) begin
                  m_state = 4; if (m_trip < 255) m_trip++;
               end
            4: if (zynq_wdog_timeout) begin
                  m_state = 0; m_en = 0;
               end
            default: m_state = 0;
         endcase
      end
      m_enable_prev = enable;
      m_hb_prev = health_hb;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else        model_step();
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("cyc_state", state, m_state);
         chk("cyc_wdg_en", wdg_en, m_en);
         chk("cyc_wdg_kick", wdg_kick, m_kick);
         chk("cyc_fault_mask", fault_mask, m_fault);
         chk("cyc_trip_cnt", trip_cnt, m_trip);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
      if (wdg_kick === 1'b1) kicks++;
   endtask

   // Each tick: one tick cycle then three quiet cycles; masked heartbeats
   // toggle on the first quiet cycle of every third tick.
   task automatic ticks(input int n, input logic [N_HB-1:0] mask);
      for (int k = 1; k <= n; k++) begin
         clk_10hz_fp = 1'b1;
         cyc();
         clk_10hz_fp = 1'b0;
         if (k % 3 == 0) health_hb = health_hb ^ mask;
         cyc(); cyc(); cyc();
      end
   endtask

   initial begin
      #400000;
      $display("FAIL sim_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      clk_10hz_fp = 0; enable = 0; force_stop = 0; health_hb = '0;
      zynq_wdog_timeout = 1; rst_n = 1;
      #2 rst_n = 0;
      repeat (3) @(posedge clk);
      #1;
      chk_on = 1;
      chk("reset_state", state, 0);
      chk("reset_wdg_en", wdg_en, 0);
      chk("reset_trip_cnt", trip_cnt, 0);
      rst_n = 1;
      cyc();

      // Arm and run with healthy heartbeats
      enable = 1;
      cyc();
      chk("arm_state", state, 1);
      chk("arm_kick", wdg_kick, 1);
      chk("arm_wdg_en", wdg_en, 1);
      cyc();
      chk("run_state", state, 2);
      chk("run_no_kick", wdg_kick, 0);
      kicks = 0;
      ticks(12, 2'b11);
      chk("healthy_kicks", kicks, 3);
      chk("healthy_fault", fault_mask, 0);
      chk("healthy_state", state, 2);

      // hb[1] goes stale: fault on 8th tick, kick due on that tick is dropped
      kicks = 0;
      ticks(8, 2'b01);
      chk("stale_kicks", kicks, 1);
      chk("stale_fault", fault_mask, 2);
      chk("stale_state", state, 3);
      zynq_wdog_timeout = 0;
      cyc();
      chk("trip_state", state, 4);
      chk("trip_cnt_1", trip_cnt, 1);
      cyc(); cyc();
      chk("trip_cnt_held", trip_cnt, 1);
      zynq_wdog_timeout = 1;
      cyc();
      chk("trip_release_state", state, 0);
      chk("trip_release_en", wdg_en, 0);

      // enable held high after a trip must not re-arm
      cyc(); cyc(); cyc();
      chk("no_rearm_state", state, 0);
      chk("no_rearm_fault_kept", fault_mask, 2);
      enable = 0;
      cyc();
      enable = 1;
      cyc();
      chk("rearm_state", state, 1);
      chk("rearm_kick", wdg_kick, 1);
      chk("rearm_fault_clr", fault_mask, 0);
      cyc();

      // force_stop coinciding with a due kick
      ticks(3, 2'b11);
      clk_10hz_fp = 1; force_stop = 1;
      cyc();
      clk_10hz_fp = 0;
      chk("force_state", state, 3);
      chk("force_no_kick", wdg_kick, 0);
      chk("force_fault", fault_mask, 0);
      force_stop = 0;
      cyc(); cyc();
      chk("force_release_state", state, 3);

      // enable dropped mid-STARVE and mid-RUN
      enable = 0;
      cyc();
      chk("drop_starve_state", state, 0);
      chk("drop_starve_en", wdg_en, 0);
      enable = 1;
      cyc(); cyc();
      ticks(2, 2'b11);
      enable = 0;
      cyc();
      chk("drop_run_state", state, 0);
      chk("drop_run_en", wdg_en, 0);

      // asynchronous reset mid-RUN
      enable = 1;
      cyc(); cyc();
      ticks(1, 2'b11);
      rst_n = 0;
      #1;
      chk("rst_state", state, 0);
      chk("rst_en", wdg_en, 0);
      chk("rst_fault", fault_mask, 0);
      chk("rst_trip", trip_cnt, 0);
      @(posedge clk);
      #1;
      enable = 0;
      rst_n = 1;
      cyc();

      // trip counter saturation via unexpected timeouts in RUN
      for (int t = 0; t < 256; t++) begin
         enable = 1;
         cyc(); cyc();
         zynq_wdog_timeout = 0;
         cyc();
         zynq_wdog_timeout = 1;
         cyc();
         enable = 0;
         cyc();
         if (t == 254) chk("trip_cnt_255", trip_cnt, 255);
      end
      chk("trip_cnt_sat", trip_cnt, 255);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
